// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared types and encodings for the memory-stage LSU.
// Holds the FSM state enum, Funct3 size/sign codes, the ResultSrc load code
// and small helpers for lane alignment and byte enables.
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Funct3 load/store encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size is Funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // ResultSrc value that marks a load in the M stage
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    // Force the byte offset down to the natural alignment of the access size
    function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return off;
            SZ_HALF: return {off[1], 1'b0};
            SZ_WORD: return 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    // Byte enables for an already aligned offset
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: request/response bus between the LSU and data memory.
interface mem_stage_lsu_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_load_extend.sv
// mem_stage_lsu_load_extend: picks the addressed byte/half lane out of the
// returned word and sign- or zero-extends it according to Funct3.
module mem_stage_lsu_load_extend
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_i[{offset_i, 3'b000} +: 8];
    assign half_lane = rdata_i[{offset_i[1], 4'b0000} +: 16];

    // Extend the selected lane; a word passes straight through
    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_B:    data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_H:    data_o = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_W:    data_o = rdata_i;
            F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_lane};
            F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit. Turns a store/load in the M stage
// into one memory handshake, stalling the pipeline until it completes.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses are flagged
// on MisalignM instead of being issued; without it the low address bits are
// masked to the access size.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [2:0]      Funct3M,
    output logic            StallM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            MisalignM,
    mem_stage_lsu_if.master mem
);

    lsu_state_t      state_q;
    logic            access;
    logic            misaligned;
    logic            start;
    logic [1:0]      size;
    logic [1:0]      offset_d, offset_q;
    logic [3:0]      be_d, be_q;
    logic [XLEN-1:0] wdata_d, wdata_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] read_data_q;
    logic [XLEN-1:0] load_data;
    logic            we_q;
    logic [2:0]      funct3_q;

    assign access   = MemWriteM | (ResultSrcM == RESULTSRC_LOAD);
    assign size     = Funct3M[1:0];
    assign offset_d = align_offset(size, ALUResultM[1:0]);
    assign be_d     = byte_enable(size, offset_d);
    assign start    = access & ~misaligned;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    assign misaligned = ((size == SZ_HALF) && ALUResultM[0]) ||
                        ((size == SZ_WORD) && (ALUResultM[1:0] != 2'b00));

    // One-cycle trap flag for a misaligned access seen while idle
    always_ff @(posedge clk) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= (state_q == ST_IDLE) && access && misaligned;
    end

    assign MisalignM = misalign_q;
`else
    assign misaligned = 1'b0;
    assign MisalignM  = 1'b0;
`endif

    // Store data replicated across every lane so the byte enables pick it up
    always_comb begin
        wdata_d = WriteDataM;
        case (size)
            SZ_BYTE: wdata_d = {(XLEN/8){WriteDataM[7:0]}};
            SZ_HALF: wdata_d = {(XLEN/16){WriteDataM[15:0]}};
            default: wdata_d = WriteDataM;
        endcase
    end

    mem_stage_lsu_load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata_i  (mem.mem_rdata),
        .offset_i (offset_q),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    // Access FSM: request attributes are latched on leaving IDLE so the bus
    // stays stable even if the M-stage inputs wobble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            read_data_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            offset_q    <= 2'b00;
            funct3_q    <= 3'b000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_REQ;
                        addr_q   <= {ALUResultM[XLEN-1:2], 2'b00};
                        wdata_q  <= wdata_d;
                        be_q     <= be_d;
                        we_q     <= MemWriteM;
                        offset_q <= offset_d;
                        funct3_q <= Funct3M;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ready) state_q <= we_q ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem.mem_rvalid) begin
                        read_data_q <= load_data;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stall rises in the same cycle the access is seen; reset wins over everything
    assign StallM = rst_n & (((state_q == ST_IDLE) & start) |
                             (state_q == ST_REQ) | (state_q == ST_WAIT));

    assign mem.mem_req   = rst_n & (state_q == ST_REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;
    assign ReadDataM     = read_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed plus randomized checks of mem_stage_lsu against
// an arithmetic reference model of byte lanes, extension and stall length.
// Honours MISALIGN_TRAP_EN when the build defines it.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  Funct3M;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MisalignM;

    always #5 clk = ~clk;

    mem_stage_lsu_if #(.XLEN(32)) mem_bus ();

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .Funct3M    (Funct3M),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .MisalignM  (MisalignM),
        .mem        (mem_bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: shift the addressed lane down, mask, then extend by arithmetic
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] rd, input int off);
        logic [31:0] sh, v;
        sh = rd >> (8 * off);
        case (f3)
            3'b000: begin v = sh & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
            3'b001: begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            3'b100: v = sh & 32'hFF;
            3'b101: v = sh & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    // One complete access with a reactive memory model; ends at the negedge after DONE
    task automatic run_access(input bit store, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int ready_lat, input int rv_lat, input bit early);
        int          off, stalls, hs, req_cyc, hs_cyc, e_stall;
        bit          done;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        off = int'(addr % 4);
        if (f3[1:0] == 2'd1)      off = off - (off % 2);
        else if (f3[1:0] == 2'd2) off = 0;
        case (f3[1:0])
            2'd0:    begin e_be = 4'(1 << off); e_wdata = (wd & 32'hFF) * 32'h01010101;   end
            2'd1:    begin e_be = 4'(3 << off); e_wdata = (wd & 32'hFFFF) * 32'h00010001; end
            default: begin e_be = 4'hF;         e_wdata = wd;                             end
        endcase
        e_stall = 2 + ready_lat + (store ? 0 : rv_lat);
        if (!store) exp_rd = exp_load(f3, rd, off);
        stalls = 0; hs = 0; req_cyc = 0; hs_cyc = -1; done = 0;
        MemWriteM  = store;
        ResultSrcM = store ? 2'($urandom_range(0, 3)) : 2'b01;
        ALUResultM = addr;
        WriteDataM = wd;
        Funct3M    = f3;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            mem_bus.mem_ready  = early && (cyc == 0);
            mem_bus.mem_rvalid = early && (cyc == 0);
            mem_bus.mem_rdata  = $urandom;
            #1;
            if (StallM !== 1'b1) begin
                done = 1;
            end else begin
                stalls++;
                if (mem_bus.mem_req === 1'b1) begin
                    chk("mem_addr", mem_bus.mem_addr, addr & 32'hFFFF_FFFC);
                    chk("mem_be", 32'(mem_bus.mem_be), 32'(e_be));
                    chk("mem_we", 32'(mem_bus.mem_we), 32'(store));
                    if (store) chk("mem_wdata", mem_bus.mem_wdata, e_wdata);
                    if (req_cyc >= ready_lat) begin
                        mem_bus.mem_ready = 1'b1;
                        hs++;
                        hs_cyc = cyc;
                    end
                    req_cyc++;
                end
                if (!store && hs_cyc >= 0 && cyc == hs_cyc + rv_lat) begin
                    mem_bus.mem_rvalid = 1'b1;
                    mem_bus.mem_rdata  = rd;
                end
                @(negedge clk);
            end
        end
        chk("done_in_budget", 32'(done), 32'd1);
        chk("stall_cycles", stalls, e_stall);
        chk("handshakes", hs, 32'd1);
        chk("done_req_low", 32'(mem_bus.mem_req), 32'd0);
        chk("read_data", ReadDataM, exp_rd);
        chk("misalign_low", 32'(MisalignM), 32'd0);
        $display("txn %s f3=%0d addr=%h wd=%h rd=%h stall=%0d readdata=%h",
                 store ? "ST" : "LD", f3, addr, wd, rd, stalls, ReadDataM);
        @(negedge clk);
    endtask

    // Non-access cycles with bus noise; nothing may move
    task automatic idle_cycles(input int n);
        int v;
        for (int i = 0; i < n; i++) begin
            v = $urandom_range(0, 2);
            MemWriteM  = 1'b0;
            ResultSrcM = (v == 0) ? 2'b00 : (v == 1) ? 2'b10 : 2'b11;
            ALUResultM = $urandom;
            mem_bus.mem_ready  = 1'($urandom_range(0, 1));
            mem_bus.mem_rvalid = 1'($urandom_range(0, 1));
            mem_bus.mem_rdata  = $urandom;
            #1;
            chk("idle_stall", 32'(StallM), 32'd0);
            chk("idle_req", 32'(mem_bus.mem_req), 32'd0);
            chk("idle_readdata", ReadDataM, exp_rd);
            @(negedge clk);
        end
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        bit          st;
        int          k, gap;
        logic [2:0]  f3;
        logic [31:0] a;

        exp_rd     = 32'd0;
        rst_n      = 1'b0;
        MemWriteM  = 1'b1;
        ResultSrcM = 2'b01;
        ALUResultM = 32'h100;
        WriteDataM = 32'd0;
        Funct3M    = 3'b010;
        mem_bus.mem_ready  = 1'b1;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(StallM), 32'd0);
        chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst_readdata", ReadDataM, 32'd0);
        chk("rst_misalign", 32'(MisalignM), 32'd0);
        MemWriteM = 1'b0; ResultSrcM = 2'b00; mem_bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        idle_cycles(2);

        // Directed cases
        run_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 0, 1, 1'b0);
        run_access(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'd0, 0, 1, 1'b0);
        run_access(1'b0, 3'b000, 32'h102, 32'd0, 32'h0080FF00, 0, 3, 1'b0);
        chk("lb_sign_ext", ReadDataM, 32'hFFFFFF80);
        run_access(1'b0, 3'b101, 32'h102, 32'd0, 32'h80010000, 0, 1, 1'b0);
        chk("lhu_zero_ext", ReadDataM, 32'h00008001);
        run_access(1'b1, 3'b001, 32'h20, 32'h1234CAFE, 32'd0, 2, 1, 1'b1);
        chk("store_keeps_readdata", ReadDataM, 32'h00008001);

`ifdef MISALIGN_TRAP_EN
        MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h101;
        #1;
        chk("mis_stall", 32'(StallM), 32'd0);
        chk("mis_req0", 32'(mem_bus.mem_req), 32'd0);
        @(negedge clk);
        #1;
        chk("mis_flag", 32'(MisalignM), 32'd1);
        chk("mis_req1", 32'(mem_bus.mem_req), 32'd0);
        ResultSrcM = 2'b00;
        @(negedge clk);
        #1;
        chk("mis_flag_clear", 32'(MisalignM), 32'd0);
        @(negedge clk);
`else
        run_access(1'b0, 3'b010, 32'h101, 32'd0, 32'h12345678, 1, 2, 1'b1);
`endif
        idle_cycles(1);

        // Reset while REQ is waiting for mem_ready
        MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b000; ALUResultM = 32'h200;
        @(negedge clk);
        #1;
        chk("rstreq_req_before", 32'(mem_bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstreq_req_gated", 32'(mem_bus.mem_req), 32'd0);
        chk("rstreq_stall_gated", 32'(StallM), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; ResultSrcM = 2'b00;
        exp_rd = 32'd0;
        #1;
        chk("rstreq_idle_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rstreq_idle_stall", 32'(StallM), 32'd0);
        chk("rstreq_readdata", ReadDataM, 32'd0);
        @(negedge clk);

        // Reset while WAIT, followed by a late rvalid that must be ignored
        ResultSrcM = 2'b01; Funct3M = 3'b000; ALUResultM = 32'h102;
        @(negedge clk);
        #1;
        chk("rstwait_req", 32'(mem_bus.mem_req), 32'd1);
        mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        mem_bus.mem_ready = 1'b0;
        #1;
        chk("rstwait_stall_in_wait", 32'(StallM), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstwait_stall_gated", 32'(StallM), 32'd0);
        chk("rstwait_req_gated", 32'(mem_bus.mem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; ResultSrcM = 2'b00;
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h0080FF00;
        #1;
        chk("rstwait_idle_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rstwait_idle_stall", 32'(StallM), 32'd0);
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b0;
        #1;
        chk("rstwait_late_rvalid", ReadDataM, 32'd0);
        @(negedge clk);

        // Randomized accesses
        for (int t = 0; t < 40; t++) begin
            st = 1'($urandom_range(0, 1));
            if (st) begin
                k  = $urandom_range(0, 2);
                f3 = 3'(k);
            end else begin
                k  = $urandom_range(0, 4);
                f3 = (k < 3) ? 3'(k) : 3'(k + 1);
            end
            a = $urandom;
`ifdef MISALIGN_TRAP_EN
            if (f3[1:0] == 2'd1) a = a & 32'hFFFF_FFFE;
            if (f3[1:0] == 2'd2) a = a & 32'hFFFF_FFFC;
`endif
            run_access(st, f3, a, $urandom, $urandom, $urandom_range(0, 3),
                       $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            gap = $urandom_range(0, 2);
            if (gap > 0) idle_cycles(gap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
